multimode_drive: RTL and testbench

//  Parametrised successor to the single-mode overdrive stage in the pedal chain.

---
 rtl/multimode_drive_if.sv | 26 ++
 rtl/multimode_drive.sv | 128 ++++++++++++
 tb/tb_multimode_drive.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/multimode_drive_if.sv
// Start/Done handshake and sample bus for the multimode overdrive stage.
// The master drives the request and settings; the slave returns status and the result.
interface multimode_drive_if #(
    parameter int DATA_W  = 16,
    parameter int GAIN_W  = 4,
    parameter int LEVEL_W = 3
);
    logic                      start;
    logic signed [DATA_W-1:0]  input_frame;
    logic [1:0]                mode;
    logic [GAIN_W-1:0]         gain;
    logic [LEVEL_W-1:0]        level;
    logic                      busy;
    logic                      done;
    logic signed [DATA_W-1:0]  output_frame;

    modport master (
        output start, input_frame, mode, gain, level,
        input  busy, done, output_frame
    );

    modport slave (
        input  start, input_frame, mode, gain, level,
        output busy, done, output_frame
    );
endinterface

// File: rtl/multimode_drive.sv
// Multimode overdrive: gain, selectable clip curve, output level; one frame per Start/Done.
// Five-state sequencer (IDLE/GAIN/SHAPE/LEVEL/DONE), one stage per clock.
module multimode_drive #(
    parameter int DATA_W  = 16,
    parameter int GAIN_W  = 4,
    parameter int LEVEL_W = 3,
    parameter int THRESH  = 8192
) (
    input  logic              clk,
    input  logic              rst,
    multimode_drive_if.slave  bus
);
    localparam int P_W = DATA_W + GAIN_W + 1;
    localparam int Y_W = P_W + LEVEL_W + 2;

    localparam logic signed [P_W-1:0] TH_POS = P_W'(THRESH);
    localparam logic signed [P_W-1:0] TH_NEG = -P_W'(THRESH);
    localparam logic signed [P_W-1:0] FZ_NEG = -P_W'(THRESH / 2);
    localparam logic signed [Y_W-1:0] Y_MAX  = Y_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [Y_W-1:0] Y_MIN  = -Y_W'(2 ** (DATA_W - 1));

    typedef enum logic [2:0] {
        ST_IDLE, ST_GAIN, ST_SHAPE, ST_LEVEL, ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic signed [DATA_W-1:0] x_reg;
    logic [1:0]               mode_reg;
    logic [GAIN_W-1:0]        gain_reg;
    logic [LEVEL_W-1:0]       level_reg;
    logic signed [P_W-1:0]    p_reg, p_next;
    logic signed [P_W-1:0]    s_reg, s_next;
    logic signed [DATA_W-1:0] out_reg, out_next;

    logic [GAIN_W:0]          gain_factor;
    logic [LEVEL_W:0]         level_factor;
    logic signed [P_W-1:0]    x_ext, abs_p, soft_mag;
    logic signed [Y_W-1:0]    y_prod, y_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_GAIN;
            ST_GAIN:  state_next = ST_SHAPE;
            ST_SHAPE: state_next = ST_LEVEL;
            ST_LEVEL: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_reg != ST_IDLE);
        bus.done = (state_reg == ST_DONE);
    end

    assign bus.output_frame = out_reg;

    // Gain stage: clean mode bypasses the multiplier entirely.
    always_comb begin
        gain_factor = {1'b0, gain_reg} + {{GAIN_W{1'b0}}, 1'b1};
        x_ext       = P_W'(x_reg);
        p_next      = (mode_reg == 2'b00) ? x_ext : x_ext * $signed(P_W'(gain_factor));
    end

    always_comb begin
        abs_p    = p_reg[P_W-1] ? -p_reg : p_reg;
        soft_mag = TH_POS + ((abs_p - TH_POS) >>> 2);
        s_next   = p_reg;
        case (mode_reg)
            2'b01: begin
                if (p_reg > TH_POS)      s_next = TH_POS;
                else if (p_reg < TH_NEG) s_next = TH_NEG;
            end
            2'b10: begin
                if (abs_p > TH_POS) s_next = p_reg[P_W-1] ? -soft_mag : soft_mag;
            end
            2'b11: begin
                // Negative half clips at half the threshold for the asymmetric fuzz tone.
                if (p_reg > TH_POS)      s_next = TH_POS;
                else if (p_reg < FZ_NEG) s_next = FZ_NEG;
            end
            default: s_next = p_reg;
        endcase
    end

    always_comb begin
        level_factor = {1'b0, level_reg} + {{LEVEL_W{1'b0}}, 1'b1};
        y_prod       = Y_W'(s_reg) * $signed(Y_W'(level_factor));
        y_shift      = y_prod >>> LEVEL_W;
        if (y_shift > Y_MAX)      out_next = {1'b0, {(DATA_W-1){1'b1}}};
        else if (y_shift < Y_MIN) out_next = {1'b1, {(DATA_W-1){1'b0}}};
        else                      out_next = y_shift[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= '0;
            mode_reg  <= '0;
            gain_reg  <= '0;
            level_reg <= '0;
            p_reg     <= '0;
            s_reg     <= '0;
            out_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_reg     <= bus.input_frame;
                        mode_reg  <= bus.mode;
                        gain_reg  <= bus.gain;
                        level_reg <= bus.level;
                    end
                end
                ST_GAIN:  p_reg   <= p_next;
                ST_SHAPE: s_reg   <= s_next;
                ST_LEVEL: out_reg <= out_next;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multimode_drive.sv
// Self-checking bench for multimode_drive: directed table, corner sequences, random vs. model.
module tb_multimode_drive;
    localparam longint T = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;

    multimode_drive_if #(.DATA_W(16), .GAIN_W(4), .LEVEL_W(3)) bus ();

    multimode_drive #(.DATA_W(16), .GAIN_W(4), .LEVEL_W(3), .THRESH(8192)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] x;
        logic [1:0]         mode;
        logic [3:0]         gain;
        logic [2:0]         level;
        logic signed [15:0] expect_y;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: gain, curve, level scaling with floor division, then saturation.
    function automatic longint model(longint x, int m, int g, int l);
        longint p, s, a, prod, y;
        p = (m == 0) ? x : x * (g + 1);
        a = (p < 0) ? -p : p;
        case (m)
            0: s = p;
            1: s = (p > T) ? T : ((p < -T) ? -T : p);
            2: s = (a <= T) ? p : ((p < 0) ? -(T + (a - T) / 4) : (T + (a - T) / 4));
            default: s = (p > T) ? T : ((p < -(T / 2)) ? -(T / 2) : p);
        endcase
        prod = s * (l + 1);
        y = prod / 8;
        if ((prod % 8 != 0) && (prod < 0)) y = y - 1;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    task automatic run_txn(input logic signed [15:0] x, input logic [1:0] m,
                           input logic [3:0] g, input logic [2:0] l,
                           input logic signed [15:0] exp, input string tag);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        bus.input_frame = x; bus.mode = m; bus.gain = g; bus.level = l; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Scramble the inputs: the result must depend only on what was latched.
        bus.input_frame = 16'($urandom);
        bus.mode  = 2'($urandom);
        bus.gain  = 4'($urandom);
        bus.level = 3'($urandom);
        cyc = 0;
        busy_cnt = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
        end
        check({tag, " latency"}, cyc, 4);
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " output"}, bus.output_frame, exp);
        @(negedge clk);
        check({tag, " done_width"}, bus.done, 0);
        check({tag, " idle_after"}, bus.busy, 0);
        $display("txn %s: x=%0d mode=%0d gain=%0d level=%0d y=%0d exp=%0d lat=%0d",
                 tag, x, m, g, l, bus.output_frame, exp, cyc);
    endtask

    initial begin
        logic signed [15:0] xa, xb, ea, eb, hold_val;
        int n_done, first_at, second_at, r;
        logic [1:0] rm;
        logic [3:0] rg;
        logic [2:0] rl;
        logic signed [15:0] rx;

        vecs[0] = '{16'sd1000,   2'b01, 4'd3,  3'd7, 16'sd4000};
        vecs[1] = '{-16'sd1000,  2'b01, 4'd15, 3'd7, -16'sd8192};
        vecs[2] = '{16'sd1000,   2'b10, 4'd15, 3'd3, 16'sd5072};
        vecs[3] = '{-16'sd1000,  2'b11, 4'd15, 3'd7, -16'sd4096};
        vecs[4] = '{16'sd1000,   2'b11, 4'd15, 3'd7, 16'sd8192};
        vecs[5] = '{-16'sd32768, 2'b00, 4'd15, 3'd7, -16'sd32768};
        vecs[6] = '{-16'sd32768, 2'b00, 4'd15, 3'd0, -16'sd4096};
        vecs[7] = '{16'sd32767,  2'b00, 4'd0,  3'd0, 16'sd4095};

        bus.start = 1'b0; bus.input_frame = '0; bus.mode = '0; bus.gain = '0; bus.level = '0;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset output", bus.output_frame, 0);
        rst = 1'b0;

        foreach (vecs[i])
            run_txn(vecs[i].x, vecs[i].mode, vecs[i].gain, vecs[i].level, vecs[i].expect_y,
                    $sformatf("vec%0d", i));

        // Start pulsed while in SHAPE must be ignored.
        xa = 16'sd1500; xb = -16'sd700;
        ea = 16'(model(xa, 1, 2, 7));
        @(negedge clk);
        bus.input_frame = xa; bus.mode = 2'b01; bus.gain = 4'd2; bus.level = 3'd7; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.input_frame = xb;
        @(negedge clk);
        bus.start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) n_done++;
            @(negedge clk);
        end
        check("busy_start done_count", n_done, 1);
        check("busy_start output", bus.output_frame, ea);
        check("busy_start idle", bus.busy, 0);
        $display("txn busy_start: dones=%0d y=%0d exp=%0d", n_done, bus.output_frame, ea);

        // Reset asserted in SHAPE aborts with no Done.
        @(negedge clk);
        bus.input_frame = 16'sd2000; bus.mode = 2'b00; bus.gain = 4'd0; bus.level = 3'd7; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort output", bus.output_frame, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort no_done", n_done, 0);
        check("abort output_after", bus.output_frame, 0);
        $display("txn abort: dones=%0d y=%0d", n_done, bus.output_frame);

        // Start held high: back-to-back frames every 5 cycles, re-latching current inputs.
        xa = 16'sd300; xb = -16'sd2500;
        ea = 16'(model(xa, 2, 15, 5));
        eb = 16'(model(xb, 2, 15, 5));
        @(negedge clk);
        bus.input_frame = xa; bus.mode = 2'b10; bus.gain = 4'd15; bus.level = 3'd5; bus.start = 1'b1;
        n_done = 0; first_at = -1; second_at = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    first_at = i;
                    check("held first output", bus.output_frame, ea);
                    bus.input_frame = xb;
                end else begin
                    second_at = i;
                    check("held second output", bus.output_frame, eb);
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("held first_done_at", first_at, 4);
        check("held period", second_at - first_at, 5);
        $display("txn held: first=%0d second=%0d", first_at, second_at);
        repeat (6) @(negedge clk);

        // Random frames against the reference model, plus output-hold check between them.
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: begin
                    case ($urandom_range(0, 3))
                        0: rx = -16'sd32768;
                        1: rx = 16'sd32767;
                        2: rx = 16'sd0;
                        default: rx = -16'sd1;
                    endcase
                end
                default: rx = 16'($urandom);
            endcase
            rm = 2'($urandom);
            rg = 4'($urandom);
            rl = 3'($urandom);
            ea = 16'(model(rx, rm, rg, rl));
            run_txn(rx, rm, rg, rl, ea, $sformatf("rnd%0d", k));
            hold_val = ea;
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                @(negedge clk);
                bus.input_frame = 16'($urandom);
            end
            check("random hold", bus.output_frame, hold_val);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
